game_round_ctrl: RTL

Round sequencer for the whack-a-mole game. It owns the game-second prescaler, the 5-bit time-left counter and the score counter, and it picks the active mole hole with an LFSR. It qualifies player button presses as hits or misses and drives the IDLE/PLAY/GAMEOVER flow. It sits between the debounced push-buttons and the display/LED drivers.

---
 rtl/game_round_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: round sequencer for the whack-a-mole game.
// Owns the game-second prescaler, the mole dwell counter, the time-left and
// score counters, and an 8-bit LFSR that picks the active hole. Button and
// start inputs are edge-detected through a registered history stage.
// Optional feature macro: MISS_PENALTY_EN (a miss subtracts one second).
module game_round_ctrl #(
    parameter int TICK_CYCLES = 100000000,
    parameter int MOLE_CYCLES = 75000000,
    parameter int NUM_HOLES   = 4,
    parameter int TIME_INIT   = 30,
    parameter int TIME_MAX    = 30,
    parameter int TIME_BONUS  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] hit_btn,
    output logic [NUM_HOLES-1:0] mole,
    output logic [4:0]           time_left,
    output logic [7:0]           score,
    output logic                 tick,
    output logic [1:0]           state,
    output logic                 game_over
);

    localparam int PW = $clog2(TICK_CYCLES);
    localparam int DW = $clog2(MOLE_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] DWELL_LAST  = DW'(MOLE_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DWELL_ONE   = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [4:0]    TIME_INIT_V = 5'(TIME_INIT);
    localparam logic [4:0]    TIME_MAX_V  = 5'(TIME_MAX);
    localparam logic [NUM_HOLES-1:0] NO_MOLE = {NUM_HOLES{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_lfsr;
    logic                 r_start_q;
    logic                 r_start_prev;
    logic [NUM_HOLES-1:0] r_hit_q;
    logic [NUM_HOLES-1:0] r_hit_prev;
    logic [PW-1:0]        r_presc;
    logic [DW-1:0]        r_dwell;
    logic [NUM_HOLES-1:0] r_mole;
    logic [4:0]           r_time;
    logic [7:0]           r_score;
    logic                 r_tick;
    logic                 r_game_over;

    logic [PW-1:0]        w_presc_nxt;
    logic [DW-1:0]        w_dwell_nxt;
    logic [NUM_HOLES-1:0] w_mole_nxt;
    logic [4:0]           w_time_nxt;
    logic [7:0]           w_score_nxt;
    logic                 w_tick_nxt;

    logic                 w_start_rise;
    logic [NUM_HOLES-1:0] w_hit_rise;
    logic                 w_hit;
    logic                 w_tick_now;
    logic [7:0]           w_time_up;
    logic [7:0]           w_time_dn;
    logic [7:0]           w_time_diff;
    logic [4:0]           w_time_clamp;
    logic [2:0]           w_cur_idx;
    logic [2:0]           w_raw_idx;
    logic [2:0]           w_pick_idx;
    logic [NUM_HOLES-1:0] w_pick_mole;

    assign w_start_rise = r_start_q & ~r_start_prev;
    assign w_hit_rise   = r_hit_q & ~r_hit_prev;
    assign w_hit        = |(w_hit_rise & r_mole);
    assign w_tick_now   = (r_presc == PRESC_LAST);
    assign w_time_up    = {3'b000, r_time} + (w_hit ? 8'(TIME_BONUS) : 8'd0);

`ifdef MISS_PENALTY_EN
    logic w_miss;
    assign w_miss    = |(w_hit_rise & ~r_mole);
    assign w_time_dn = {7'd0, w_tick_now} + {7'd0, w_miss};
`else
    assign w_time_dn = {7'd0, w_tick_now};
`endif

    assign w_time_diff = w_time_up - w_time_dn;

    // Clamp the combined same-cycle time update into [0, TIME_MAX].
    always_comb begin
        if (w_time_up <= w_time_dn) begin
            w_time_clamp = 5'd0;
        end else if (w_time_diff >= {3'b000, TIME_MAX_V}) begin
            w_time_clamp = TIME_MAX_V;
        end else begin
            w_time_clamp = w_time_diff[4:0];
        end
    end

    // Pick the next hole from the LFSR, bumping past the currently shown hole.
    always_comb begin
        w_cur_idx = 3'd0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            if (r_mole[i]) begin
                w_cur_idx = 3'(i);
            end else begin
                w_cur_idx = w_cur_idx;
            end
        end
        w_raw_idx = 3'({29'd0, r_lfsr[2:0]} % 32'(NUM_HOLES));
        if ((|r_mole) && (w_raw_idx == w_cur_idx)) begin
            w_pick_idx = (({29'd0, w_raw_idx} + 32'd1) == 32'(NUM_HOLES)) ? 3'd0 : (w_raw_idx + 3'd1);
        end else begin
            w_pick_idx = w_raw_idx;
        end
        w_pick_mole = {{(NUM_HOLES-1){1'b0}}, 1'b1} << w_pick_idx;
    end

    // Next-state and next-output logic for the IDLE/PLAY/GAMEOVER flow.
    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_dwell_nxt = r_dwell;
        w_mole_nxt  = r_mole;
        w_time_nxt  = r_time;
        w_score_nxt = r_score;
        w_tick_nxt  = 1'b0;
        case (r_state)
            ST_IDLE, ST_OVER: begin
                w_mole_nxt = NO_MOLE;
                if (w_start_rise) begin
                    w_state_nxt = ST_PLAY;
                    w_time_nxt  = TIME_INIT_V;
                    w_score_nxt = 8'd0;
                    w_presc_nxt = {PW{1'b0}};
                    w_dwell_nxt = {DW{1'b0}};
                    w_mole_nxt  = w_pick_mole;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_PLAY: begin
                if (r_time == 5'd0) begin
                    // Time ran out on the previous update: close the round.
                    w_state_nxt = ST_OVER;
                    w_mole_nxt  = NO_MOLE;
                end else begin
                    w_presc_nxt = w_tick_now ? {PW{1'b0}} : (r_presc + PRESC_ONE);
                    w_tick_nxt  = w_tick_now;
                    w_time_nxt  = w_time_clamp;
                    w_score_nxt = (w_hit && (r_score != 8'hFF)) ? (r_score + 8'd1) : r_score;
                    if (w_hit || (r_dwell == DWELL_LAST)) begin
                        w_mole_nxt  = w_pick_mole;
                        w_dwell_nxt = {DW{1'b0}};
                    end else begin
                        w_dwell_nxt = r_dwell + DWELL_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_mole_nxt  = NO_MOLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_presc     <= {PW{1'b0}};
            r_dwell     <= {DW{1'b0}};
            r_mole      <= NO_MOLE;
            r_time      <= TIME_INIT_V;
            r_score     <= 8'd0;
            r_tick      <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_presc     <= w_presc_nxt;
            r_dwell     <= w_dwell_nxt;
            r_mole      <= w_mole_nxt;
            r_time      <= w_time_nxt;
            r_score     <= w_score_nxt;
            r_tick      <= w_tick_nxt;
            r_game_over <= (w_state_nxt == ST_OVER);
        end
    end

    // Edge-detect history for start and hole buttons.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_start_q    <= 1'b0;
            r_start_prev <= 1'b0;
            r_hit_q      <= NO_MOLE;
            r_hit_prev   <= NO_MOLE;
        end else begin
            r_start_q    <= start;
            r_start_prev <= r_start_q;
            r_hit_q      <= hit_btn;
            r_hit_prev   <= r_hit_q;
        end
    end

    // Free-running Fibonacci LFSR, taps 8,6,5,4; non-zero seed keeps it off all-zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign mole      = r_mole;
    assign time_left = r_time;
    assign score     = r_score;
    assign tick      = r_tick;
    assign state     = r_state;
    assign game_over = r_game_over;

endmodule
